hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the EX-stage operand-forwarding logic and resolves the hazards forwarding cannot cover:
- load-use stalls
- taken-branch flushes
- multi-cycle mul/div occupancy

It drives the PC/IF-ID write enables and the bubble/flush controls, and sequences mul/div waits with an FSM and a watchdog counter.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/sat_counter.sv | 22 ++
 rtl/hazard_stall_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO          = 5'd0;
    localparam int         MD_MAX_CYCLES_DEF = 64;
    localparam int         CNT_W_DEF         = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-flush / mul-div stall controller for the 5-stage pipeline.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_MAX_CYCLES = MD_MAX_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_memread,
    input  logic [4:0]       idex_regt,
    input  logic [4:0]       ifid_regs,
    input  logic [4:0]       ifid_regt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             md_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             ex_hold,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] perf_load_stall,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_md_stall
);

    localparam int              WD_W     = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MD_MAX_CYCLES);

    md_state_e       state;
    md_state_e       state_nx;
    logic [WD_W-1:0] watchdog;
    logic [WD_W-1:0] watchdog_nx;
    logic            timeout_nx;
    logic            load_use;

    // Register zero is hard-wired, so a load targeting it never creates a dependency.
    assign load_use = idex_memread && (idex_regt != REG_ZERO) &&
                      ((idex_regt == ifid_regs) || (ifid_uses_rt && (idex_regt == ifid_regt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            watchdog   <= '0;
            md_timeout <= 1'b0;
        end else begin
            state      <= state_nx;
            watchdog   <= watchdog_nx;
            md_timeout <= timeout_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        watchdog_nx = watchdog;
        timeout_nx  = md_timeout;
        case (state)
            IDLE: begin
                if (!branch_taken && md_start) begin
                    state_nx    = MD_BUSY;
                    watchdog_nx = WD_W'(1);
                end
            end
            MD_BUSY: begin
                // A completion arriving on the limit cycle wins over the timeout.
                if (md_done) begin
                    state_nx    = IDLE;
                    watchdog_nx = '0;
                end else if (watchdog == WD_LIMIT) begin
                    state_nx    = IDLE;
                    watchdog_nx = '0;
                    timeout_nx  = 1'b1;
                end else begin
                    watchdog_nx = watchdog + 1'b1;
                end
            end
            default: begin
                state_nx    = IDLE;
                watchdog_nx = '0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        case (state)
            IDLE: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (!md_start && load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MD_BUSY: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ex_hold    = 1'b1;
            end
            default: begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        endcase
    end

    assign md_busy = (state == MD_BUSY);

`ifdef HAZARD_PERF_CNT_EN
    logic ev_load_stall;
    logic ev_flush;
    logic ev_md_stall;

    assign ev_load_stall = (state == IDLE) && !branch_taken && !md_start && load_use;
    assign ev_flush      = (state == IDLE) && branch_taken;
    assign ev_md_stall   = (state == MD_BUSY);

    sat_counter #(.CNT_W(CNT_W)) u_cnt_load_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (ev_load_stall),
        .count (perf_load_stall)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (ev_flush),
        .count (perf_flush)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_md_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (ev_md_stall),
        .count (perf_md_stall)
    );
`else
    assign perf_load_stall = '0;
    assign perf_flush      = '0;
    assign perf_md_stall   = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (default watchdog and a short one of 4)
// share the same stimulus; directed scenarios plus a randomized run against a model.
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       idex_memread = 1'b0;
    logic [4:0] idex_regt = '0;
    logic [4:0] ifid_regs = '0;
    logic [4:0] ifid_regt = '0;
    logic       ifid_uses_rt = 1'b0;
    logic       branch_taken = 1'b0;
    logic       md_start = 1'b0;
    logic       md_done = 1'b0;

    logic        pc_write [2];
    logic        ifid_write [2];
    logic        ifid_flush [2];
    logic        idex_bubble [2];
    logic        ex_hold [2];
    logic        md_busy [2];
    logic        md_timeout [2];
    logic [31:0] perf_load_stall [2];
    logic [31:0] perf_flush [2];
    logic [31:0] perf_md_stall [2];

    int n_pass = 0;
    int n_total = 0;

    // Reference model: per-instance view of "is an op running and for how long".
    int maxc [2] = '{64, 4};
    bit m_busy [2];
    int m_elapsed [2];
    bit m_to [2];
    int m_ls [2];
    int m_fl [2];
    int m_md [2];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_MAX_CYCLES(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_regt(idex_regt),
        .ifid_regs(ifid_regs), .ifid_regt(ifid_regt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .md_start(md_start), .md_done(md_done),
        .pc_write(pc_write[0]), .ifid_write(ifid_write[0]), .ifid_flush(ifid_flush[0]),
        .idex_bubble(idex_bubble[0]), .ex_hold(ex_hold[0]), .md_busy(md_busy[0]),
        .md_timeout(md_timeout[0]), .perf_load_stall(perf_load_stall[0]),
        .perf_flush(perf_flush[0]), .perf_md_stall(perf_md_stall[0])
    );

    hazard_stall_ctrl #(.MD_MAX_CYCLES(4), .CNT_W(32)) dut_wd (
        .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_regt(idex_regt),
        .ifid_regs(ifid_regs), .ifid_regt(ifid_regt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .md_start(md_start), .md_done(md_done),
        .pc_write(pc_write[1]), .ifid_write(ifid_write[1]), .ifid_flush(ifid_flush[1]),
        .idex_bubble(idex_bubble[1]), .ex_hold(ex_hold[1]), .md_busy(md_busy[1]),
        .md_timeout(md_timeout[1]), .perf_load_stall(perf_load_stall[1]),
        .perf_flush(perf_flush[1]), .perf_md_stall(perf_md_stall[1])
    );

    function automatic logic [31:0] exp_cnt(int v);
        return PERF_EN ? 32'(v) : 32'd0;
    endfunction

    function automatic bit ref_load_use();
        logic [4:0] srcs [$];
        if (!idex_memread || idex_regt == 5'd0) return 1'b0;
        srcs.push_back(ifid_regs);
        if (ifid_uses_rt) srcs.push_back(ifid_regt);
        foreach (srcs[k]) if (srcs[k] == idex_regt) return 1'b1;
        return 1'b0;
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, md_busy, md_timeout}
    function automatic logic [6:0] exp_flags(int i);
        if (m_busy[i])     return {6'b000011, m_to[i]};
        if (branch_taken)  return {6'b111100, m_to[i]};
        if (md_start)      return {6'b110000, m_to[i]};
        if (ref_load_use()) return {6'b000100, m_to[i]};
        return {6'b110000, m_to[i]};
    endfunction

    function automatic logic [6:0] obs_flags(int i);
        return {pc_write[i], ifid_write[i], ifid_flush[i], idex_bubble[i],
                ex_hold[i], md_busy[i], md_timeout[i]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_elapsed[i] = 0; m_to[i] = 0;
            m_ls[i] = 0; m_fl[i] = 0; m_md[i] = 0;
        end
    endtask

    task automatic model_tick();
        bit lu;
        lu = ref_load_use();
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (!m_busy[i]) begin
                if (branch_taken) m_fl[i]++;
                else if (md_start) begin m_busy[i] = 1; m_elapsed[i] = 1; end
                else if (lu) m_ls[i]++;
            end else begin
                m_md[i]++;
                if (md_done) m_busy[i] = 0;
                else if (m_elapsed[i] == maxc[i]) begin m_busy[i] = 0; m_to[i] = 1; end
                else m_elapsed[i]++;
            end
        end
    endtask

    task automatic clear_inputs();
        idex_memread = 0; idex_regt = 0; ifid_regs = 0; ifid_regt = 0;
        ifid_uses_rt = 0; branch_taken = 0; md_start = 0; md_done = 0;
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        model_clear();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_total++; if (obs_flags(i) !== 7'b1100000) $display("FAIL reset_flags[%0d] got %b exp %b", i, obs_flags(i), 7'b1100000); else n_pass++;
            n_total++; if ({perf_load_stall[i], perf_flush[i], perf_md_stall[i]} !== 96'd0) $display("FAIL reset_cnt[%0d] got %h exp 0", i, {perf_load_stall[i], perf_flush[i], perf_md_stall[i]}); else n_pass++;
        end
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        apply_reset();
        idex_memread = 1; idex_regt = 5'd8; ifid_regs = 5'd8;
        @(negedge clk);
        n_total++; if ({pc_write[0], ifid_write[0], idex_bubble[0], ifid_flush[0]} !== 4'b0010) $display("FAIL lu_rs got %b exp 0010", {pc_write[0], ifid_write[0], idex_bubble[0], ifid_flush[0]}); else n_pass++;
        advance();
        ifid_regs = 5'd9; ifid_uses_rt = 0; ifid_regt = 5'd8;
        @(negedge clk);
        n_total++; if ({pc_write[0], ifid_write[0], idex_bubble[0]} !== 3'b110) $display("FAIL lu_rt_unused got %b exp 110", {pc_write[0], ifid_write[0], idex_bubble[0]}); else n_pass++;
        advance();
        ifid_uses_rt = 1;
        @(negedge clk);
        n_total++; if ({pc_write[0], ifid_write[0], idex_bubble[0]} !== 3'b001) $display("FAIL lu_rt_used got %b exp 001", {pc_write[0], ifid_write[0], idex_bubble[0]}); else n_pass++;
        advance();
        idex_regt = 5'd0; ifid_regs = 5'd0; ifid_regt = 5'd0;
        @(negedge clk);
        n_total++; if ({pc_write[0], ifid_write[0], idex_bubble[0]} !== 3'b110) $display("FAIL lu_reg_zero got %b exp 110", {pc_write[0], ifid_write[0], idex_bubble[0]}); else n_pass++;
        advance();
        clear_inputs();
        @(negedge clk);
        n_total++; if (perf_load_stall[0] !== exp_cnt(2)) $display("FAIL lu_perf got %0d exp %0d", perf_load_stall[0], exp_cnt(2)); else n_pass++;
        advance();
    endtask

    task automatic test_branch();
        apply_reset();
        idex_memread = 1; idex_regt = 5'd8; ifid_regs = 5'd8; branch_taken = 1;
        @(negedge clk);
        n_total++; if ({ifid_flush[0], idex_bubble[0], pc_write[0], ifid_write[0]} !== 4'b1111) $display("FAIL br_over_lu got %b exp 1111", {ifid_flush[0], idex_bubble[0], pc_write[0], ifid_write[0]}); else n_pass++;
        n_total++; if (perf_flush[0] !== 32'd0) $display("FAIL br_perf_before got %0d exp 0", perf_flush[0]); else n_pass++;
        advance();
        clear_inputs();
        @(negedge clk);
        n_total++; if (perf_flush[0] !== exp_cnt(1)) $display("FAIL br_perf_flush got %0d exp %0d", perf_flush[0], exp_cnt(1)); else n_pass++;
        n_total++; if (perf_load_stall[0] !== 32'd0) $display("FAIL br_perf_ls got %0d exp 0", perf_load_stall[0]); else n_pass++;
        advance();
        branch_taken = 1; md_start = 1;
        advance();
        clear_inputs();
        @(negedge clk);
        n_total++; if (md_busy[0] !== 1'b0) $display("FAIL br_squash_md got %b exp 0", md_busy[0]); else n_pass++;
        advance();
    endtask

    task automatic test_muldiv();
        apply_reset();
        md_start = 1;
        advance();
        md_start = 0;
        for (int k = 1; k <= 5; k++) begin
            md_done = (k == 5);
            branch_taken = (k == 3);
            @(negedge clk);
            n_total++; if ({md_busy[0], ex_hold[0], pc_write[0], ifid_write[0], ifid_flush[0]} !== 5'b11000) $display("FAIL md_wait k=%0d got %b exp 11000", k, {md_busy[0], ex_hold[0], pc_write[0], ifid_write[0], ifid_flush[0]}); else n_pass++;
            advance();
        end
        clear_inputs();
        md_start = 1;
        @(negedge clk);
        n_total++; if ({md_busy[0], pc_write[0], ex_hold[0]} !== 3'b010) $display("FAIL md_after got %b exp 010", {md_busy[0], pc_write[0], ex_hold[0]}); else n_pass++;
        n_total++; if (perf_md_stall[0] !== exp_cnt(5)) $display("FAIL md_perf got %0d exp %0d", perf_md_stall[0], exp_cnt(5)); else n_pass++;
        n_total++; if (perf_flush[0] !== 32'd0) $display("FAIL md_branch_ignored got %0d exp 0", perf_flush[0]); else n_pass++;
        advance();
        md_start = 0;
        @(negedge clk);
        n_total++; if (md_busy[0] !== 1'b1) $display("FAIL md_back_to_back got %b exp 1", md_busy[0]); else n_pass++;
        md_done = 1;
        advance();
        clear_inputs();
    endtask

    task automatic test_watchdog();
        apply_reset();
        md_start = 1;
        advance();
        md_start = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_total++; if ({md_busy[1], md_timeout[1]} !== 2'b10) $display("FAIL wd_busy k=%0d got %b exp 10", k, {md_busy[1], md_timeout[1]}); else n_pass++;
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++; if ({md_busy[1], md_timeout[1]} !== 2'b01) $display("FAIL wd_timeout k=%0d got %b exp 01", k, {md_busy[1], md_timeout[1]}); else n_pass++;
            advance();
        end
        md_start = 1;
        advance();
        md_start = 0;
        @(negedge clk);
        n_total++; if ({md_busy[1], md_timeout[1]} !== 2'b11) $display("FAIL wd_restart got %b exp 11", {md_busy[1], md_timeout[1]}); else n_pass++;
        md_done = 1;
        advance();
        clear_inputs();
    endtask

    task automatic test_simul_done();
        apply_reset();
        md_start = 1;
        advance();
        md_start = 0;
        for (int k = 1; k <= 4; k++) begin
            md_done = (k == 4);
            advance();
        end
        clear_inputs();
        @(negedge clk);
        n_total++; if ({md_busy[1], md_timeout[1]} !== 2'b00) $display("FAIL simul_done got %b exp 00", {md_busy[1], md_timeout[1]}); else n_pass++;
        advance();
    endtask

    task automatic test_async_reset();
        apply_reset();
        md_start = 1;
        advance();
        md_start = 0;
        for (int k = 0; k < 4; k++) advance();
        #2;
        rst_n = 0;
        #1;
        model_clear();
        n_total++; if ({md_busy[0], md_busy[1], md_timeout[1]} !== 3'b000) $display("FAIL async_rst_state got %b exp 000", {md_busy[0], md_busy[1], md_timeout[1]}); else n_pass++;
        n_total++; if (perf_md_stall[0] !== 32'd0) $display("FAIL async_rst_cnt got %0d exp 0", perf_md_stall[0]); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_total++; if ({pc_write[0], ifid_write[0], md_busy[0]} !== 3'b110) $display("FAIL async_rst_after got %b exp 110", {pc_write[0], ifid_write[0], md_busy[0]}); else n_pass++;
        advance();
    endtask

    task automatic test_random();
        logic [4:0] picks [4];
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            picks[0] = 5'd0; picks[1] = 5'd8; picks[2] = 5'd9; picks[3] = 5'($urandom_range(0, 31));
            idex_memread = 1'($urandom_range(0, 1));
            idex_regt    = picks[$urandom_range(0, 3)];
            ifid_regs    = picks[$urandom_range(0, 3)];
            ifid_regt    = picks[$urandom_range(0, 3)];
            ifid_uses_rt = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 5) == 0);
            md_start     = ($urandom_range(0, 3) == 0);
            md_done      = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_total++; if (obs_flags(i) !== exp_flags(i)) $display("FAIL rand_flags[%0d] cyc %0d got %b exp %b", i, c, obs_flags(i), exp_flags(i)); else n_pass++;
                n_total++; if ({perf_load_stall[i], perf_flush[i], perf_md_stall[i]} !== {exp_cnt(m_ls[i]), exp_cnt(m_fl[i]), exp_cnt(m_md[i])}) $display("FAIL rand_cnt[%0d] cyc %0d got %h exp %h", i, c, {perf_load_stall[i], perf_flush[i], perf_md_stall[i]}, {exp_cnt(m_ls[i]), exp_cnt(m_fl[i]), exp_cnt(m_md[i])}); else n_pass++;
            end
            advance();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_watchdog();
        test_simul_done();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
